// File: rtl/seven_seg_capture_if.sv
// ---------------------------------------------------------------------------
// seven_seg_capture_if
// Purpose : time-multiplexed seven-segment bus as seen by the capture block.
// Signals : i_strobe  one-cycle sample qualifier
//           i_digit   digit select for the sample (1 = tens, 0 = ones)
//           i_seg     7-bit active-low segment pattern, bit 0 = top,
//                     bits 1/2 = right, 3 = bottom, 4/5 = left, 6 = middle
// Modports: master drives the bus (display path / stimulus),
//           slave samples it (seven_seg_capture).
// ---------------------------------------------------------------------------
interface seven_seg_capture_if;
    logic       i_strobe;
    logic       i_digit;
    logic [6:0] i_seg;

    modport master (output i_strobe, output i_digit, output i_seg);
    modport slave  (input  i_strobe, input  i_digit, input  i_seg);
endinterface

// File: rtl/seven_seg_capture.sv
// ---------------------------------------------------------------------------
// seven_seg_capture
// Purpose : samples a two-digit multiplexed seven-segment bus, decodes each
//           digit back to BCD and reports a value only after STABLE identical
//           consecutive valid frames.
// Params  : STABLE  consecutive identical frames needed to report (1..15)
// Ports   : i_clk      system clock, rising edge
//           i_rst      synchronous active-high reset
//           bus        seven_seg_capture_if.slave (strobe, digit, segments)
//           o_ten      reported tens digit (BCD)
//           o_one      reported ones digit (BCD)
//           o_bin      reported value in binary, 0..99
//           o_valid    one-cycle pulse when the reported value changes
//           o_locked   high once any value has been reported
//           o_err      one-cycle pulse on a frame with an undecodable digit
//           o_err_cnt  saturating invalid-frame count
// Build   : define SEVEN_CAP_ERRCNT_EN to build the invalid-frame counter;
//           without it o_err_cnt is tied to zero.
// ---------------------------------------------------------------------------
module seven_seg_capture #(
    parameter int unsigned STABLE = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seven_seg_capture_if.slave  bus,
    output logic [3:0]          o_ten,
    output logic [3:0]          o_one,
    output logic [6:0]          o_bin,
    output logic                o_valid,
    output logic                o_locked,
    output logic                o_err,
    output logic [7:0]          o_err_cnt
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    typedef enum logic [0:0] {
        WAIT_TEN = 1'b0,
        WAIT_ONE = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       latch_ten_s, frame_done_s;
    logic [6:0] tens_seg_q;
    logic [3:0] cand_ten_q, cand_ten_d, cand_one_q, cand_one_d;
    logic [3:0] cnt_q, cnt_d;
    logic       report_s;
    logic [4:0] ten_dec_s, one_dec_s;
    logic [3:0] ten_q, ten_d, one_q, one_d;
    logic [6:0] bin_q, bin_d;
    logic       valid_q, valid_d, locked_q, locked_d, err_q, err_d;

    // Exact-match pattern decoder: returns {is_valid, bcd}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: seg_decode = {1'b1, 4'd0};
            7'b1111001: seg_decode = {1'b1, 4'd1};
            7'b0100100: seg_decode = {1'b1, 4'd2};
            7'b0110000: seg_decode = {1'b1, 4'd3};
            7'b0011001: seg_decode = {1'b1, 4'd4};
            7'b0010010: seg_decode = {1'b1, 4'd5};
            7'b0000010: seg_decode = {1'b1, 4'd6};
            7'b1011000: seg_decode = {1'b1, 4'd7};
            7'b0000000: seg_decode = {1'b1, 4'd8};
            7'b0010000: seg_decode = {1'b1, 4'd9};
            default:    seg_decode = {1'b0, 4'd0};
        endcase
    endfunction

    // Frame FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= WAIT_TEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state: a tens strobe always (re)starts a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_TEN: begin
                if (bus.i_strobe && bus.i_digit) state_d = WAIT_ONE;
                else                             state_d = WAIT_TEN;
            end
            WAIT_ONE: begin
                if (bus.i_strobe && !bus.i_digit) state_d = WAIT_TEN;
                else                              state_d = WAIT_ONE;
            end
            default: state_d = WAIT_TEN;
        endcase
    end

    // Frame FSM outputs: latch tens in either state, complete only in WAIT_ONE.
    always_comb begin
        latch_ten_s  = 1'b0;
        frame_done_s = 1'b0;
        case (state_q)
            WAIT_TEN: begin
                latch_ten_s  = bus.i_strobe && bus.i_digit;
                frame_done_s = 1'b0;
            end
            WAIT_ONE: begin
                latch_ten_s  = bus.i_strobe && bus.i_digit;
                frame_done_s = bus.i_strobe && !bus.i_digit;
            end
            default: begin
                latch_ten_s  = 1'b0;
                frame_done_s = 1'b0;
            end
        endcase
    end

    assign ten_dec_s = seg_decode(tens_seg_q);
    assign one_dec_s = seg_decode(bus.i_seg);

    // Stability tracking: candidate value and saturating match count.
    always_comb begin
        cand_ten_d = cand_ten_q;
        cand_one_d = cand_one_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        report_s   = 1'b0;
        if (frame_done_s) begin
            if (!(ten_dec_s[4] && one_dec_s[4])) begin
                err_d = 1'b1;
                cnt_d = 4'd0;
            end else if ((ten_dec_s[3:0] == cand_ten_q) && (one_dec_s[3:0] == cand_one_q)) begin
                if (cnt_q < STABLE_C) begin
                    cnt_d    = cnt_q + 4'd1;
                    report_s = ((cnt_q + 4'd1) == STABLE_C);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                // A new candidate restarts at one, which already reaches STABLE=1.
                cand_ten_d = ten_dec_s[3:0];
                cand_one_d = one_dec_s[3:0];
                cnt_d      = 4'd1;
                report_s   = (STABLE_C == 4'd1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Reported value update; re-reaching STABLE on the same value is silent.
    always_comb begin
        ten_d    = ten_q;
        one_d    = one_q;
        bin_d    = bin_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        if (report_s && (!locked_q || (cand_ten_d != ten_q) || (cand_one_d != one_q))) begin
            ten_d    = cand_ten_d;
            one_d    = cand_one_d;
            bin_d    = {cand_ten_d, 3'b000} + {2'b00, cand_ten_d, 1'b0} + {3'b000, cand_one_d};
            locked_d = 1'b1;
            valid_d  = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tens_seg_q <= 7'h7F;
            cand_ten_q <= 4'd0;
            cand_one_q <= 4'd0;
            cnt_q      <= 4'd0;
            ten_q      <= 4'd0;
            one_q      <= 4'd0;
            bin_q      <= 7'd0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (latch_ten_s) tens_seg_q <= bus.i_seg;
            else             tens_seg_q <= tens_seg_q;
            cand_ten_q <= cand_ten_d;
            cand_one_q <= cand_one_d;
            cnt_q      <= cnt_d;
            ten_q      <= ten_d;
            one_q      <= one_d;
            bin_q      <= bin_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

`ifdef SEVEN_CAP_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Invalid-frame count, saturating at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        else                               err_cnt_d = err_cnt_q;
    end

    // Invalid-frame counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = 8'd0;
`endif

    assign o_ten    = ten_q;
    assign o_one    = one_q;
    assign o_bin    = bin_q;
    assign o_valid  = valid_q;
    assign o_locked = locked_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_capture
// Self-checking bench: a STABLE=3 instance driven from a frame table plus
// hand-written sequences, and a STABLE=1 instance for single-frame reporting.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_seven_seg_capture;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
    localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P7 = 7'b1011000;
    localparam logic [6:0] P9 = 7'b0010000, PBAD = 7'b1111111, IDLE = 7'b1111111;

`ifdef SEVEN_CAP_ERRCNT_EN
    localparam logic [7:0] EC1 = 8'd1, ECMAX = 8'd255;
`else
    localparam logic [7:0] EC1 = 8'd0, ECMAX = 8'd0;
`endif

    logic clk, rst;
    int   n_pass, n_total;

    seven_seg_capture_if bus3 ();
    seven_seg_capture_if bus1 ();

    logic [3:0] ten3, one3, ten1, one1;
    logic [6:0] bin3, bin1;
    logic       valid3, locked3, err3, valid1, locked1, err1;
    logic [7:0] ec3, ec1;

    seven_seg_capture #(.STABLE(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .bus(bus3.slave),
        .o_ten(ten3), .o_one(one3), .o_bin(bin3), .o_valid(valid3),
        .o_locked(locked3), .o_err(err3), .o_err_cnt(ec3)
    );

    seven_seg_capture #(.STABLE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1.slave),
        .o_ten(ten1), .o_one(one1), .o_bin(bin1), .o_valid(valid1),
        .o_locked(locked1), .o_err(err1), .o_err_cnt(ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] tseg;
        logic [6:0] oseg;
        logic       v;
        logic       e;
        logic       l;
        logic [6:0] bin;
        logic [3:0] ten;
        logic [3:0] one;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input int act, input int exp);
        n_total = n_total + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // which: 0 = both instances, 1 = STABLE=1 instance, 3 = STABLE=3 instance
    task automatic put(input int which, input logic stb, input logic dig, input logic [6:0] seg);
        @(negedge clk);
        if (which != 1) begin
            bus3.i_strobe = stb; bus3.i_digit = dig; bus3.i_seg = seg;
        end
        if (which != 3) begin
            bus1.i_strobe = stb; bus1.i_digit = dig; bus1.i_seg = seg;
        end
    endtask

    // Tens then ones on consecutive cycles; returns at the sampling point
    // one cycle after the ones strobe.
    task automatic frame(input int which, input logic [6:0] t, input logic [6:0] o);
        put(which, 1'b1, 1'b1, t);
        put(which, 1'b1, 1'b0, o);
        put(which, 1'b0, 1'b0, IDLE);
    endtask

    task automatic check_outs(input int which, input string tag, input logic v, input logic e,
                              input logic l, input logic [6:0] bin, input logic [3:0] ten,
                              input logic [3:0] one, input logic [7:0] ec);
        if (which == 3) begin
            check({tag, " valid"}, int'(valid3), int'(v));
            check({tag, " err"}, int'(err3), int'(e));
            check({tag, " locked"}, int'(locked3), int'(l));
            check({tag, " bin"}, int'(bin3), int'(bin));
            check({tag, " ten"}, int'(ten3), int'(ten));
            check({tag, " one"}, int'(one3), int'(one));
            check({tag, " errcnt"}, int'(ec3), int'(ec));
            check({tag, " valid_and_err"}, int'(valid3 & err3), 0);
        end else begin
            check({tag, " valid"}, int'(valid1), int'(v));
            check({tag, " err"}, int'(err1), int'(e));
            check({tag, " locked"}, int'(locked1), int'(l));
            check({tag, " bin"}, int'(bin1), int'(bin));
            check({tag, " ten"}, int'(ten1), int'(ten));
            check({tag, " one"}, int'(one1), int'(one));
            check({tag, " errcnt"}, int'(ec1), int'(ec));
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // 42 locks on the 3rd frame; repeats and interrupted 99 runs stay silent;
        // a full 99 run reports; an error clears the count mid-run.
        tbl[0]  = '{P4, P2,   1'b0, 1'b0, 1'b0, 7'd0,  4'd0, 4'd0, 8'd0};
        tbl[1]  = '{P4, P2,   1'b0, 1'b0, 1'b0, 7'd0,  4'd0, 4'd0, 8'd0};
        tbl[2]  = '{P4, P2,   1'b1, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[3]  = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[4]  = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[5]  = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[6]  = '{P9, P9,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[7]  = '{P9, P9,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[8]  = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[9]  = '{P9, P9,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[10] = '{P9, P9,   1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, 8'd0};
        tbl[11] = '{P9, P9,   1'b1, 1'b0, 1'b1, 7'd99, 4'd9, 4'd9, 8'd0};
        tbl[12] = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd99, 4'd9, 4'd9, 8'd0};
        tbl[13] = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd99, 4'd9, 4'd9, 8'd0};
        tbl[14] = '{P4, PBAD, 1'b0, 1'b1, 1'b1, 7'd99, 4'd9, 4'd9, EC1};
        tbl[15] = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd99, 4'd9, 4'd9, EC1};
        tbl[16] = '{P4, P2,   1'b0, 1'b0, 1'b1, 7'd99, 4'd9, 4'd9, EC1};
        tbl[17] = '{P4, P2,   1'b1, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, EC1};

        rst = 1'b1;
        bus3.i_strobe = 1'b0; bus3.i_digit = 1'b0; bus3.i_seg = IDLE;
        bus1.i_strobe = 1'b0; bus1.i_digit = 1'b0; bus1.i_seg = IDLE;
        repeat (3) @(negedge clk);
        check_outs(3, "reset", 1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            frame(3, tbl[i].tseg, tbl[i].oseg);
            check_outs(3, $sformatf("row%0d", i), tbl[i].v, tbl[i].e, tbl[i].l,
                       tbl[i].bin, tbl[i].ten, tbl[i].one, tbl[i].ec);
        end
        // valid is a single-cycle pulse
        @(negedge clk);
        check("valid_pulse_width", int'(valid3), 0);

        // Out-of-order stream: orphan ones, tens resync, then 70 completes.
        put(3, 1'b1, 1'b0, P5);
        put(3, 1'b1, 1'b1, P1);
        put(3, 1'b1, 1'b1, P7);
        put(3, 1'b1, 1'b0, P0);
        put(3, 1'b0, 1'b0, IDLE);
        check_outs(3, "ooo_f1", 1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, EC1);
        frame(3, P7, P0);
        check_outs(3, "ooo_f2", 1'b0, 1'b0, 1'b1, 7'd42, 4'd4, 4'd2, EC1);
        frame(3, P7, P0);
        check_outs(3, "ooo_f3", 1'b1, 1'b0, 1'b1, 7'd70, 4'd7, 4'd0, EC1);

        // 300 invalid frames saturate the counter.
        for (int i = 0; i < 300; i++) frame(3, P4, PBAD);
        check_outs(3, "bad300", 1'b0, 1'b1, 1'b1, 7'd70, 4'd7, 4'd0, ECMAX);

        // Reset between tens and ones; a tens strobe during reset is dropped
        // and the orphan ones afterwards is discarded.
        put(0, 1'b1, 1'b1, P4);
        put(0, 1'b1, 1'b1, P4);
        rst = 1'b1;
        put(0, 1'b1, 1'b0, P2);
        rst = 1'b0;
        put(0, 1'b0, 1'b0, IDLE);
        check_outs(3, "midrst3", 1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0, 8'd0);
        check_outs(1, "midrst1", 1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 4'd0, 8'd0);

        // STABLE=1: every new value reports on its first frame.
        frame(1, P0, P5);
        check_outs(1, "s1_f1", 1'b1, 1'b0, 1'b1, 7'd5, 4'd0, 4'd5, 8'd0);
        frame(1, P0, P5);
        check_outs(1, "s1_f2", 1'b0, 1'b0, 1'b1, 7'd5, 4'd0, 4'd5, 8'd0);
        frame(1, P1, P9);
        check_outs(1, "s1_f3", 1'b1, 1'b0, 1'b1, 7'd19, 4'd1, 4'd9, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side counterpart of the team's two-digit seven-segment encoder. Samples a time-multiplexed seven-segment bus (segment pattern plus digit select), decodes each digit's pattern back to BCD, and requires a configurable number of identical consecutive frames before reporting a new value. Used on the DE2-115 test harness to read back what the display path drives and to check it against expected scores or values.

## Interface
- STABLE, default 3: number of consecutive identical valid frames before a value is reported; legal range 1..15.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_strobe  in  1  one-cycle qualifier; i_seg and i_digit are sampled only when high.
- i_digit  in  1  digit select for the sample: 1 = tens, 0 = ones.
- i_seg  in  7  segment pattern, active-low (1 = dark), bit 0 = top, bits 1/2 = right, 3 = bottom, 4/5 = left, 6 = middle.
- o_ten  out  4  reported tens digit, BCD.
- o_one  out  4  reported ones digit, BCD.
- o_bin  out  7  reported value in binary, o_ten*10 + o_one, range 0..99.
- o_valid  out  1  one-cycle pulse when the reported value changes.
- o_locked  out  1  high once any value has been reported; cleared only by reset.
- o_err  out  1  one-cycle pulse when a frame contains an undecodable pattern.
- o_err_cnt  out  8  invalid-frame count. See Configuration.

## Operation
- Decode table, exact match only: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000. Any other pattern is invalid.
- Frame FSM, states WAIT_TEN and WAIT_ONE. Reset state is WAIT_TEN.
  - In WAIT_TEN, a tens strobe latches the tens pattern and moves to WAIT_ONE. A ones strobe is discarded and the FSM stays in WAIT_TEN.
  - In WAIT_ONE, a tens strobe overwrites the latched tens pattern and the FSM stays in WAIT_ONE (resync). A ones strobe completes the frame and returns the FSM to WAIT_TEN.
- Frame evaluation, on completion:
  - If either digit is invalid: pulse o_err, clear the stability count to 0, discard the frame.
  - Else, if the frame equals the candidate: the count increments, saturating at STABLE.
  - Else: the candidate becomes this frame and the count becomes 1.
- Report condition: the count reaches STABLE on this frame (it was below STABLE before it).
  - If o_locked=0, or the candidate differs from {o_ten,o_one}: update o_ten, o_one and o_bin, pulse o_valid, set o_locked.
  - If the candidate equals the reported value: no o_valid pulse.
- o_bin is computed from the candidate digits as ten*8 + ten*2 + one, registered with the digits, 7 bits, no overflow.

## Timing
- All outputs are registered. Reset values: o_ten=0, o_one=0, o_bin=0, o_valid=0, o_locked=0, o_err=0, o_err_cnt=0. Reset also clears the candidate and count and forces WAIT_TEN.
- Latency:
  - o_valid, o_err and all updated outputs are visible the cycle after the completing ones strobe.
  - With STABLE=N, a value that is steady from reset is reported 1 cycle after the Nth frame's ones strobe.
- Back-to-back strobes on consecutive cycles are supported; every strobe is consumed.
- o_valid and o_err never assert in the same cycle.
- i_rst high with i_strobe high: reset wins and the sample is dropped.
- Reset mid-frame: the latched tens is discarded.

## Configuration
- SEVEN_CAP_ERRCNT_EN defined: o_err_cnt increments on every o_err pulse, saturates at 255, and is cleared only by reset.
- SEVEN_CAP_ERRCNT_EN undefined: o_err_cnt is tied to 0 and the counter logic is not built. All other behaviour is identical.

## Test plan
- STABLE=3, reset, then 3 frames of (tens=D4 pattern 0011001, ones=D2 pattern 0100100) -> o_valid pulses once, one cycle after the 3rd ones strobe; o_ten=4, o_one=2, o_bin=42, o_locked=1.
- Reported 42, then 3 more 42 frames -> no o_valid pulse. Then 2 frames of 99 followed by 1 frame of 42 -> no report. Then 3 frames of 99 -> o_bin=99 with a single o_valid pulse.
- Frame with ones=1111111 -> o_err pulses, count resets; a following 42 sequence needs 3 fresh frames to report. With the macro, o_err_cnt=1; after 300 bad frames it reads 255.
- Out-of-order stream: ones strobe first, then tens=D1, tens=D7, ones=D0 -> the frame decodes as 70.
- i_rst asserted for one cycle between a tens strobe and its ones strobe -> all outputs return to 0 and the orphan ones strobe is discarded.
- STABLE=1, frames 05, 05, 19 -> o_valid pulses after the 1st and 3rd frames; o_bin reads 5 then 19.
